sram_loader: RTL

- Responder end of the SRAM load handshake: accepts a `start_sram` pulse and the `n_coef_image` select from the detection-side SRAM sequencer.
- Fetches either the image weight block or the next coefficient set from the external SRAM, word by word.
- Streams each word to the weight/coefficient buffers, then returns a one-cycle `sram_done` pulse.

---
 rtl/sram_loader_pkg.sv | 26 ++
 rtl/sram_addr_gen.sv | 26 ++
 rtl/sram_loader.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/sram_loader_pkg.sv
// Shared types and default constants for the SRAM loader.
package sram_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StCapture,
    StDone
  } state_e;

  localparam int unsigned DefAddrW      = 16;
  localparam int unsigned DefDataW      = 16;
  localparam int unsigned DefImageWords = 64;
  localparam int unsigned DefCoefWords  = 16;
  localparam int unsigned DefCoefSets   = 4;
  localparam int unsigned DefReadLat    = 2;
  localparam logic [15:0] DefImageBase  = 16'h0000;
  localparam logic [15:0] DefCoefBase   = 16'h0400;
  localparam int unsigned IdxW          = 8;

  function automatic int unsigned cs_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_addr_gen.sv
// Combinational read-address generator for image words and coefficient sets.
module sram_addr_gen
  import sram_loader_pkg::*;
#(
  parameter int unsigned       ADDR_W     = DefAddrW,
  parameter int unsigned       COEF_WORDS = DefCoefWords,
  parameter int unsigned       CS_W       = 2,
  parameter logic [ADDR_W-1:0] IMAGE_BASE = ADDR_W'(DefImageBase),
  parameter logic [ADDR_W-1:0] COEF_BASE  = ADDR_W'(DefCoefBase)
) (
  input  logic              is_image,
  input  logic [CS_W-1:0]   coef_set,
  input  logic [IdxW-1:0]   idx,
  output logic [ADDR_W-1:0] addr
);

  // All sums wrap modulo 2^ADDR_W.
  always_comb begin
    if (is_image) begin
      addr = IMAGE_BASE + ADDR_W'(idx);
    end else begin
      addr = COEF_BASE + ADDR_W'(coef_set * COEF_WORDS) + ADDR_W'(idx);
    end
  end

endmodule

// File: rtl/sram_loader.sv
// Fetches an image block or the next coefficient set from SRAM word by word and
// streams each word to the buffers, ending with a one-cycle sram_done pulse.
module sram_loader
  import sram_loader_pkg::*;
#(
  parameter int unsigned       ADDR_W      = DefAddrW,
  parameter int unsigned       DATA_W      = DefDataW,
  parameter int unsigned       IMAGE_WORDS = DefImageWords,
  parameter int unsigned       COEF_WORDS  = DefCoefWords,
  parameter int unsigned       COEF_SETS   = DefCoefSets,
  parameter logic [ADDR_W-1:0] IMAGE_BASE  = ADDR_W'(DefImageBase),
  parameter logic [ADDR_W-1:0] COEF_BASE   = ADDR_W'(DefCoefBase),
  parameter int unsigned       READ_LAT    = DefReadLat
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_sram,
  input  logic                             n_coef_image,
  output logic [ADDR_W-1:0]                sram_addr,
  output logic                             sram_read_en,
  input  logic [DATA_W-1:0]                sram_rdata,
  output logic [DATA_W-1:0]                load_data,
  output logic [IdxW-1:0]                  load_index,
  output logic                             load_is_image,
  output logic                             load_valid,
  output logic [cs_width(COEF_SETS)-1:0]   coef_set,
  output logic                             busy,
  output logic                             sram_done
);

  localparam int unsigned CsW   = cs_width(COEF_SETS);
  localparam int unsigned WaitW = (READ_LAT > 2) ? $clog2(READ_LAT) : 1;

  // The wait counter runs 0..READ_LAT-2, i.e. READ_LAT-1 cycles.
  localparam logic [WaitW-1:0] WaitLast  = WaitW'((READ_LAT > 1) ? READ_LAT - 2 : 0);
  localparam logic [IdxW-1:0]  ImageLast = IdxW'(IMAGE_WORDS - 1);
  localparam logic [IdxW-1:0]  CoefLast  = IdxW'(COEF_WORDS - 1);
  localparam logic [CsW-1:0]   CsLast    = CsW'(COEF_SETS - 1);

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             img_q, img_d;
  logic [CsW-1:0]   cs_q, cs_d;
  logic             addr_sel;
  logic [ADDR_W-1:0] gen_addr;

  sram_addr_gen #(
    .ADDR_W    (ADDR_W),
    .COEF_WORDS(COEF_WORDS),
    .CS_W      (CsW),
    .IMAGE_BASE(IMAGE_BASE),
    .COEF_BASE (COEF_BASE)
  ) u_addr_gen (
    .is_image(img_q),
    .coef_set(cs_q),
    .idx     (idx_q),
    .addr    (gen_addr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      wait_q  <= '0;
      img_q   <= 1'b0;
      cs_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      img_q   <= img_d;
      cs_q    <= cs_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wait_d       = wait_q;
    img_d        = img_q;
    cs_d         = cs_q;
    addr_sel     = 1'b0;
    sram_read_en = 1'b0;
    load_valid   = 1'b0;
    load_data    = '0;
    load_index   = '0;
    sram_done    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_sram) begin
          img_d   = n_coef_image;
          idx_d   = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        sram_read_en = 1'b1;
        addr_sel     = 1'b1;
        if (READ_LAT > 1) begin
          wait_d  = '0;
          state_d = StWait;
        end else begin
          state_d = StCapture;
        end
      end
      StWait: begin
        addr_sel = 1'b1;
        if (wait_q == WaitLast) begin
          state_d = StCapture;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StCapture: begin
        load_valid = 1'b1;
        load_data  = sram_rdata;
        load_index = idx_q;
        if (idx_q == (img_q ? ImageLast : CoefLast)) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + IdxW'(1);
          state_d = StIssue;
        end
      end
      StDone: begin
        sram_done = 1'b1;
        // A new image restarts the coefficient sequence.
        if (img_q || cs_q == CsLast) begin
          cs_d = '0;
        end else begin
          cs_d = cs_q + CsW'(1);
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign sram_addr     = addr_sel ? gen_addr : '0;
  assign load_is_image = img_q;
  assign coef_set      = cs_q;
  assign busy          = (state_q != StIdle);

endmodule
